linebuf_sched: RTL and testbench



---
 rtl/linebuf_pkg.sv | 11 +
 rtl/linebuf_bank_ram.sv | 33 +++
 rtl/linebuf_sched.sv | 197 +++++++++++++++++++
 tb/tb_linebuf_sched.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/linebuf_pkg.sv
// Shared types and default geometry for the two-bank line-buffer scheduler.
// No logic; bank, write-FSM and read-FSM state encodings live here.
package linebuf_pkg;
  localparam int LINE_WORDS_DEF = 320;
  localparam int ADDR_W_DEF     = 9;
  localparam int LINE_W_DEF     = 10;

  typedef enum logic [1:0] {FREE, FILLING, FULL, READING} bank_st_e;
  typedef enum logic [1:0] {IDLE, FILL, DROP}             wr_st_e;
  typedef enum logic [1:0] {R_IDLE, R_OFFER, R_BUSY}      rd_st_e;
endpackage

// File: rtl/linebuf_bank_ram.sv
// One line bank: WORDS x 16 simple dual-port RAM, one write port, registered read port.
// Read latency 1 cycle; no backpressure, out-of-range read addresses return 0.
module linebuf_bank_ram
  import linebuf_pkg::*;
#(
  parameter int WORDS = LINE_WORDS_DEF,
  parameter int AW    = ADDR_W_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [15:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [15:0]   rdata_o
);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(WORDS);

  logic [15:0] mem [WORDS];
  logic [15:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                          rdata_q <= '0;
    else if ({1'b0, raddr_i} < DEPTH_C)  rdata_q <= mem[raddr_i];
    else                                 rdata_q <= '0;
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/linebuf_sched.sv
// Two-bank line scheduler: captures acapture-gated lines into free banks, offers full lines oldest-first.
// acapture edges act 3 cycles after the change; a completed line is offered the next cycle if the reader is idle.
// Offer held until rd_ready; lines arriving with no free bank are dropped. Statistics need LINEBUF_STATS_EN.
module linebuf_sched
  import linebuf_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int LINE_W     = LINE_W_DEF,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              acapture,
  input  logic              wr_en,
  input  logic [15:0]       wr_data,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              rd_bank,
  output logic [ADDR_W:0]   rd_len,
  output logic [LINE_W-1:0] rd_line,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [15:0]       rd_data,
  input  logic              rd_done,
  output logic [CNT_W-1:0]  drop_count,
  output logic [CNT_W-1:0]  line_count
);
  localparam logic [ADDR_W:0] WORDS_C = (ADDR_W+1)'(LINE_WORDS);

  logic              acap_s1_q, acap_s2_q, acap_prev_q;
  logic              rise, fall, wr_ok, sel;
  bank_st_e          bank_q [2], bank_d [2];
  logic [ADDR_W:0]   blen_q [2], blen_d [2];
  logic [LINE_W-1:0] bline_q [2], bline_d [2];
  logic              oldest_q, oldest_d;
  wr_st_e            wr_q, wr_d;
  logic              fill_bank_q, fill_bank_d;
  logic [ADDR_W:0]   len_q, len_d, len_w;
  logic [LINE_W-1:0] line_idx_q, line_idx_d;
  rd_st_e            rd_q, rd_d;
  logic              rd_bank_q, rd_bank_d;
  logic [ADDR_W:0]   rd_len_q, rd_len_d;
  logic [LINE_W-1:0] rd_line_q, rd_line_d;
  logic [15:0]       ram_rdata [2];

  assign rise  = acap_s2_q & ~acap_prev_q;
  assign fall  = ~acap_s2_q & acap_prev_q;
  assign wr_ok = (wr_q == FILL) && wr_en && ({1'b0, wr_addr} < WORDS_C);

  always_comb begin
    bank_d      = bank_q;
    blen_d      = blen_q;
    bline_d     = bline_q;
    oldest_d    = oldest_q;
    wr_d        = wr_q;
    fill_bank_d = fill_bank_q;
    line_idx_d  = line_idx_q;
    rd_d        = rd_q;
    rd_bank_d   = rd_bank_q;
    rd_len_d    = rd_len_q;
    rd_line_d   = rd_line_q;
    sel         = 1'b0;
    len_w       = len_q;
    if (wr_ok && ({1'b0, wr_addr} >= len_q)) len_w = {1'b0, wr_addr} + (ADDR_W+1)'(1);
    len_d = len_w;

    // Reader transitions go first so a bank released by rd_done is free for a same-cycle capture.
    case (rd_q)
      R_OFFER: if (rd_ready) begin bank_d[rd_bank_q] = READING; rd_d = R_BUSY; end
      R_BUSY:  if (rd_done)  begin bank_d[rd_bank_q] = FREE;    rd_d = R_IDLE; end
      default: ;
    endcase

    if (frame_start) begin
      for (int b = 0; b < 2; b++)
        if (bank_d[b] == FILLING || bank_d[b] == FULL) bank_d[b] = FREE;
      if (rd_d == R_OFFER) rd_d = R_IDLE;
      wr_d       = IDLE;
      line_idx_d = '0;
    end else if (fall) begin
      if (wr_q == FILL) begin
        if (len_w != '0) begin
          bank_d[fill_bank_q]  = FULL;
          blen_d[fill_bank_q]  = len_w;
          bline_d[fill_bank_q] = line_idx_q;
          oldest_d   = (bank_d[~fill_bank_q] == FULL) ? ~fill_bank_q : fill_bank_q;
          line_idx_d = line_idx_q + LINE_W'(1);
        end else begin
          bank_d[fill_bank_q] = FREE;
        end
      end
      wr_d = IDLE;
    end

    if (rise) begin
      if (bank_d[0] == FREE) begin
        bank_d[0] = FILLING; fill_bank_d = 1'b0; wr_d = FILL; len_d = '0;
      end else if (bank_d[1] == FREE) begin
        bank_d[1] = FILLING; fill_bank_d = 1'b1; wr_d = FILL; len_d = '0;
      end else begin
        wr_d = DROP;
      end
    end

    // Looking at bank_d lets a line completed this cycle be offered on the next.
    if (rd_q == R_IDLE && (bank_d[0] == FULL || bank_d[1] == FULL)) begin
      sel       = (bank_d[0] == FULL && bank_d[1] == FULL) ? oldest_d : (bank_d[1] == FULL);
      rd_d      = R_OFFER;
      rd_bank_d = sel;
      rd_len_d  = blen_d[sel];
      rd_line_d = bline_d[sel];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acap_s1_q   <= 1'b0;
      acap_s2_q   <= 1'b0;
      acap_prev_q <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        bank_q[b]  <= FREE;
        blen_q[b]  <= '0;
        bline_q[b] <= '0;
      end
      oldest_q    <= 1'b0;
      wr_q        <= IDLE;
      fill_bank_q <= 1'b0;
      len_q       <= '0;
      line_idx_q  <= '0;
      rd_q        <= R_IDLE;
      rd_bank_q   <= 1'b0;
      rd_len_q    <= '0;
      rd_line_q   <= '0;
    end else begin
      acap_s1_q   <= acapture;
      acap_s2_q   <= acap_s1_q;
      acap_prev_q <= acap_s2_q;
      bank_q      <= bank_d;
      blen_q      <= blen_d;
      bline_q     <= bline_d;
      oldest_q    <= oldest_d;
      wr_q        <= wr_d;
      fill_bank_q <= fill_bank_d;
      len_q       <= len_d;
      line_idx_q  <= line_idx_d;
      rd_q        <= rd_d;
      rd_bank_q   <= rd_bank_d;
      rd_len_q    <= rd_len_d;
      rd_line_q   <= rd_line_d;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    linebuf_bank_ram #(.WORDS(LINE_WORDS), .AW(ADDR_W)) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (wr_ok && (fill_bank_q == 1'(g))),
      .waddr_i (wr_addr),
      .wdata_i (wr_data),
      .raddr_i (rd_addr),
      .rdata_o (ram_rdata[g])
    );
  end

  assign rd_valid = (rd_q == R_OFFER);
  assign rd_bank  = rd_bank_q;
  assign rd_len   = rd_len_q;
  assign rd_line  = rd_line_q;
  assign rd_data  = rd_bank_q ? ram_rdata[1] : ram_rdata[0];

`ifdef LINEBUF_STATS_EN
  logic             drop_ev, pub_ev;
  logic [CNT_W-1:0] drop_cnt_q, line_cnt_q;

  // Line index only advances on a publish, except the frame_start clear.
  assign drop_ev = rise && (wr_d == DROP);
  assign pub_ev  = !frame_start && (line_idx_d != line_idx_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
      line_cnt_q <= '0;
    end else begin
      if (drop_ev && !(&drop_cnt_q)) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
      if (pub_ev && !(&line_cnt_q))  line_cnt_q <= line_cnt_q + CNT_W'(1);
    end
  end

  assign drop_count = drop_cnt_q;
  assign line_count = line_cnt_q;
`else
  assign drop_count = '0;
  assign line_count = '0;
`endif
endmodule

// File: tb/tb_linebuf_sched.sv
// Scoreboard bench for linebuf_sched: stimulus pushes expected offers and read data,
// a negedge monitor pops and compares them as the DUT presents handshakes and read results.
module tb_linebuf_sched;
  import linebuf_pkg::*;

`ifdef LINEBUF_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic       bank;
    logic [9:0] len;
    logic [9:0] line;
  } offer_t;

  logic        clk = 1'b0;
  logic        rst_n, frame_start, acapture, wr_en, rd_ready, rd_done;
  logic [15:0] wr_data;
  logic [8:0]  wr_addr, rd_addr;
  logic        rd_valid, rd_bank;
  logic [9:0]  rd_len, rd_line;
  logic [15:0] rd_data;
  logic [15:0] drop_count, line_count;

  int          errors = 0;
  int          checks = 0;
  offer_t      exp_offer [$];
  logic [15:0] exp_rd [$];
  logic        rd_req = 1'b0;
  logic        req_seen = 1'b0;

  always #5 clk = ~clk;

  linebuf_sched dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .acapture(acapture),
    .wr_en(wr_en), .wr_data(wr_data), .wr_addr(wr_addr),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_bank(rd_bank), .rd_len(rd_len),
    .rd_line(rd_line), .rd_addr(rd_addr), .rd_data(rd_data), .rd_done(rd_done),
    .drop_count(drop_count), .line_count(line_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) req_seen <= rd_req;

  always @(negedge clk) begin
    if (rst_n && rd_valid && rd_ready) begin
      if (exp_offer.size() == 0) begin
        chk("unexpected_offer_bank", {31'd0, rd_bank}, 32'hFFFF_FFFF);
      end else begin
        offer_t e;
        e = exp_offer.pop_front();
        chk("offer_bank", {31'd0, rd_bank}, {31'd0, e.bank});
        chk("offer_len",  {22'd0, rd_len},  {22'd0, e.len});
        chk("offer_line", {22'd0, rd_line}, {22'd0, e.line});
      end
    end
    if (rst_n && req_seen) begin
      if (exp_rd.size() == 0) chk("unexpected_read", {16'd0, rd_data}, 32'hFFFF_FFFF);
      else                    chk("rd_data", {16'd0, rd_data}, {16'd0, exp_rd.pop_front()});
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic start_line();
    acapture = 1'b1;
    tick(4);
  endtask

  task automatic end_line();
    acapture = 1'b0;
    tick(5);
  endtask

  task automatic wr(input logic [8:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick(1);
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [8:0] a, input logic [15:0] d);
    exp_rd.push_back(d);
    rd_addr = a; rd_req = 1'b1;
    tick(1);
    rd_req = 1'b0;
    tick(2);
  endtask

  task automatic done_pulse();
    rd_done = 1'b1;
    tick(1);
    rd_done = 1'b0;
    tick(3);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rd_valid"}, {31'd0, rd_valid}, 0);
    chk({tag, "_rd_bank"},  {31'd0, rd_bank},  0);
    chk({tag, "_rd_len"},   {22'd0, rd_len},   0);
    chk({tag, "_rd_line"},  {22'd0, rd_line},  0);
    chk({tag, "_rd_data"},  {16'd0, rd_data},  0);
    chk({tag, "_drop"},     {16'd0, drop_count}, 0);
    chk({tag, "_lines"},    {16'd0, line_count}, 0);
  endtask

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; acapture = 1'b0; wr_en = 1'b0; wr_data = '0;
    wr_addr = '0; rd_ready = 1'b1; rd_addr = '0; rd_done = 1'b0;
    tick(3);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick(2);

    // Full 320-pixel line, data = address.
    exp_offer.push_back('{1'b0, 10'd320, 10'd0});
    start_line();
    for (int a = 0; a < 320; a++) wr(9'(a), 16'(a));
    end_line();
    rd(9'd5, 16'd5);
    rd(9'd319, 16'd319);
    chk("lines_after_full", {16'd0, line_count}, STATS ? 1 : 0);
    done_pulse();

    // Three lines with the reader stalled: two banks fill, third line dropped.
    rd_ready = 1'b0;
    exp_offer.push_back('{1'b0, 10'd10, 10'd1});
    exp_offer.push_back('{1'b1, 10'd20, 10'd2});
    start_line(); for (int a = 0; a < 10; a++) wr(9'(a), 16'h100 + 16'(a)); end_line();
    start_line(); for (int a = 0; a < 20; a++) wr(9'(a), 16'h200 + 16'(a)); end_line();
    start_line(); for (int a = 0; a < 5;  a++) wr(9'(a), 16'h900 + 16'(a)); end_line();
    chk("stall_valid_held", {31'd0, rd_valid}, 1);
    chk("stall_bank_held",  {31'd0, rd_bank},  0);
    chk("drop_after_three", {16'd0, drop_count}, STATS ? 1 : 0);
    chk("lines_after_three", {16'd0, line_count}, STATS ? 3 : 0);
    rd_ready = 1'b1;
    tick(2);
    rd(9'd3, 16'h103);

    // acapture rise lands in the same cycle rd_done frees bank 0.
    acapture = 1'b1;
    tick(2);
    rd_done = 1'b1;
    tick(1);
    rd_done = 1'b0;
    tick(1);
    exp_offer.push_back('{1'b0, 10'd7, 10'd3});
    for (int a = 0; a < 7; a++) wr(9'(a), 16'h300 + 16'(a));
    end_line();
    chk("drop_after_bypass", {16'd0, drop_count}, STATS ? 1 : 0);
    done_pulse();
    rd(9'd6, 16'h306);
    done_pulse();

    // Empty line and out-of-range-only line publish nothing; index does not advance.
    start_line(); end_line();
    start_line(); wr(9'd400, 16'hDEAD); end_line();
    chk("no_offer_empty_lines", {31'd0, rd_valid}, 0);
    exp_offer.push_back('{1'b0, 10'd3, 10'd4});
    start_line();
    wr(9'd2, 16'h402); wr(9'd0, 16'h400); wr(9'd450, 16'hBEEF);
    end_line();
    rd(9'd0, 16'h400);
    done_pulse();

    // frame_start mid-fill while the other bank is being read.
    exp_offer.push_back('{1'b0, 10'd4, 10'd5});
    start_line(); for (int a = 0; a < 4; a++) wr(9'(a), 16'h500 + 16'(a)); end_line();
    start_line();
    wr(9'd0, 16'h7700); wr(9'd1, 16'h7701);
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    end_line();
    exp_offer.push_back('{1'b1, 10'd6, 10'd0});
    start_line(); for (int a = 0; a < 6; a++) wr(9'(a), 16'h600 + 16'(a)); end_line();
    rd(9'd1, 16'h501);
    chk("lines_before_reset", {16'd0, line_count}, STATS ? 7 : 0);
    done_pulse();
    rd(9'd2, 16'h602);

    // Reset while the reader is busy on bank 1.
    chk("busy_bank_before_reset", {31'd0, rd_bank}, 1);
    rst_n = 1'b0;
    tick(1);
    chk_reset_outputs("busy_reset");
    rst_n = 1'b1;
    tick(2);
    chk("offers_pending", exp_offer.size(), 0);
    chk("reads_pending", exp_rd.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
